// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
package fetch_redirect_ctrl_pkg;

    // Source of a redirect: also encodes the pending-buffer state
    // (NONE = EMPTY, PRED = PEND_PRED, RES = PEND_RES).
    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_PRED = 2'd1,
        REDIR_RES  = 2'd2
    } redirect_src_t;

    // Width of the squash-window down-counter (window lengths 1..7).
    localparam int SQUASH_W = 3;

endpackage

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Saturating event counter: increments on i_inc, sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next count: advance unless already saturated.
    always_comb begin
        value_d = value_q;
        if (i_inc && (value_q != {WIDTH{1'b1}})) begin
            value_d = value_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_value = value_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates EX mispredict (res) and ID
// predicted-taken (pred) redirects, buffers one across stalls, drives the
// fetch load-PC port with zero latency, and opens a squash window after
// every applied redirect.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 26,
    parameter int SQUASH_RES  = 2,
    parameter int SQUASH_PRED = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall,
    input  logic                  i_res_valid,
    input  logic [ADDR_WIDTH-1:0] i_res_pc,
    input  logic                  i_pred_valid,
    input  logic [ADDR_WIDTH-1:0] i_pred_pc,
    output logic                  o_redirect_we,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    output logic                  o_squash,
    output logic                  o_pending,
    output logic [CNT_WIDTH-1:0]  o_res_count,
    output logic [CNT_WIDTH-1:0]  o_pred_count
);

    localparam logic [SQUASH_W-1:0] SQ_LOAD_RES  = SQUASH_W'(SQUASH_RES);
    localparam logic [SQUASH_W-1:0] SQ_LOAD_PRED = SQUASH_W'(SQUASH_PRED);

    redirect_src_t         pend_src_q, pend_src_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [SQUASH_W-1:0]   sq_cnt_q, sq_cnt_d;
    logic                  pending_q, pending_d;

    redirect_src_t         sel_src;
    logic [ADDR_WIDTH-1:0] sel_pc;
    logic                  squash_active;
    logic                  eff_pred;
    logic                  res_applied;
    logic                  pred_applied;

    assign squash_active = (sq_cnt_q != '0);
    // A pred raised by an instruction in a squashed slot is wrong-path.
    assign eff_pred      = i_pred_valid & ~squash_active;

    // Zero-latency redirect select on free cycles; oldest-first priority.
    always_comb begin
        sel_src = REDIR_NONE;
        sel_pc  = '0;
        if (!rst && !i_stall) begin
            if (i_res_valid) begin
                sel_src = REDIR_RES;
                sel_pc  = i_res_pc;
            end else if (pend_src_q == REDIR_RES) begin
                sel_src = REDIR_RES;
                sel_pc  = pend_pc_q;
            end else if (pend_src_q == REDIR_PRED) begin
                sel_src = REDIR_PRED;
                sel_pc  = pend_pc_q;
            end else if (eff_pred) begin
                sel_src = REDIR_PRED;
                sel_pc  = i_pred_pc;
            end
        end
    end

    assign res_applied  = (sel_src == REDIR_RES);
    assign pred_applied = (sel_src == REDIR_PRED);

    // Next pending buffer and squash window.
    always_comb begin
        pend_src_d = pend_src_q;
        pend_pc_d  = pend_pc_q;
        sq_cnt_d   = sq_cnt_q;
        if (i_stall) begin
            // Capture during stall; a buffered res is never displaced by pred.
            if (i_res_valid) begin
                pend_src_d = REDIR_RES;
                pend_pc_d  = i_res_pc;
            end else if (eff_pred && (pend_src_q != REDIR_RES)) begin
                pend_src_d = REDIR_PRED;
                pend_pc_d  = i_pred_pc;
            end
        end else begin
            // Free cycle: buffer drains (winner applied, losers dropped).
            pend_src_d = REDIR_NONE;
            if (res_applied) begin
                sq_cnt_d = SQ_LOAD_RES;
            end else if (pred_applied) begin
                sq_cnt_d = SQ_LOAD_PRED;
            end else if (squash_active) begin
                sq_cnt_d = sq_cnt_q - 1'b1;
            end
        end
        pending_d = (pend_src_d != REDIR_NONE);
    end

    // Control state with synchronous reset; reset drops any buffered redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_src_q <= REDIR_NONE;
            sq_cnt_q   <= '0;
            pending_q  <= 1'b0;
        end else begin
            pend_src_q <= pend_src_d;
            sq_cnt_q   <= sq_cnt_d;
            pending_q  <= pending_d;
        end
    end

    // Buffered target; only meaningful while pend_src_q != NONE.
    always_ff @(posedge clk) begin
        pend_pc_q <= pend_pc_d;
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_res_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (res_applied),
        .o_value (o_res_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_pred_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (pred_applied),
        .o_value (o_pred_count)
    );

    assign o_redirect_we = (sel_src != REDIR_NONE);
    assign o_redirect_pc = sel_pc;
    assign o_squash      = squash_active;
    assign o_pending     = pending_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl: directed scenarios then random traffic
// against a behavioural model of the redirect rules.
module tb_fetch_redirect_ctrl;

    localparam int AW   = 26;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, stall, res_v, pred_v;
    logic [AW-1:0] res_pc, pred_pc;
    logic          we, sq, pend;
    logic [AW-1:0] rpc;
    logic [CW-1:0] rcnt, pcnt;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: 0 = nothing buffered, 1 = pred buffered, 2 = res buffered.
    int            m_kind;
    logic [AW-1:0] m_pc;
    int            m_sq;
    int            m_rc, m_pcn;

    typedef struct {
        int            kind;
        logic [AW-1:0] pc;
    } cand_t;

    // Values sampled in the last step, for directed checks.
    logic          s_we, s_sq, s_pend;
    logic [AW-1:0] s_pc;
    int            s_rc, s_pcn;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(
        .ADDR_WIDTH (AW),
        .SQUASH_RES (2),
        .SQUASH_PRED(1),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (stall),
        .i_res_valid  (res_v),
        .i_res_pc     (res_pc),
        .i_pred_valid (pred_v),
        .i_pred_pc    (pred_pc),
        .o_redirect_we(we),
        .o_redirect_pc(rpc),
        .o_squash     (sq),
        .o_pending    (pend),
        .o_res_count  (rcnt),
        .o_pred_count (pcnt)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against model, clock, advance model.
    task automatic step(input logic r, input logic st, input logic rv, input logic [AW-1:0] rp,
                        input logic pv, input logic [AW-1:0] pp);
        cand_t cands[$];
        cand_t win;
        bit    eff_p;
        rst = r; stall = st; res_v = rv; res_pc = rp; pred_v = pv; pred_pc = pp;
        #1;
        eff_p = pv && (m_sq == 0);
        // Candidates in priority order; first one wins on a free cycle.
        if (rv)          cands.push_back('{2, rp});
        if (m_kind == 2) cands.push_back('{2, m_pc});
        if (m_kind == 1) cands.push_back('{1, m_pc});
        if (eff_p)       cands.push_back('{1, pp});
        win = '{0, '0};
        if (!r && !st && cands.size() > 0) win = cands[0];

        check("redirect_we", we,   (win.kind != 0) ? 1 : 0);
        check("redirect_pc", rpc,  win.pc);
        check("squash",      sq,   (m_sq != 0) ? 1 : 0);
        check("pending",     pend, (m_kind != 0) ? 1 : 0);
        check("res_count",   rcnt, m_rc);
        check("pred_count",  pcnt, m_pcn);
        s_we = we; s_pc = rpc; s_sq = sq; s_pend = pend; s_rc = int'(rcnt); s_pcn = int'(pcnt);

        @(posedge clk);
        if (r) begin
            m_kind = 0; m_sq = 0; m_rc = 0; m_pcn = 0;
        end else if (st) begin
            if (rv) begin
                m_kind = 2; m_pc = rp;
            end else if (eff_p && m_kind != 2) begin
                m_kind = 1; m_pc = pp;
            end
        end else begin
            m_kind = 0;
            if (win.kind == 2) begin
                m_sq = 2;
                if (m_rc < CMAX) m_rc++;
            end else if (win.kind == 1) begin
                m_sq = 1;
                if (m_pcn < CMAX) m_pcn++;
            end else if (m_sq > 0) begin
                m_sq--;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
    endtask

    initial begin
        rst = 1; stall = 0; res_v = 0; pred_v = 0; res_pc = '0; pred_pc = '0;
        m_kind = 0; m_pc = '0; m_sq = 0; m_rc = 0; m_pcn = 0;
        @(negedge clk);
        // Scenario 1: reset then idle.
        step(1, 0, 0, '0, 0, '0);
        step(1, 0, 0, '0, 0, '0);
        idle(10);
        check("t1_we", s_we, 0);
        check("t1_pend", s_pend, 0);
        check("t1_cnt", s_rc + s_pcn, 0);

        // Scenario 2: immediate res redirect and its squash window.
        step(0, 0, 1, 26'h100, 0, '0);
        check("t2_we", s_we, 1);
        check("t2_pc", s_pc, 26'h100);
        idle(1); check("t2_sq1", s_sq, 1);
        idle(1); check("t2_sq2", s_sq, 1);
        idle(1); check("t2_sq3", s_sq, 0);
        check("t2_rc", s_rc, 1);

        // Scenario 3: pred then res during stall; res wins on release.
        step(0, 1, 0, '0, 1, 26'h40);
        step(0, 1, 1, 26'h80, 0, '0);
        check("t3_pend", s_pend, 1);
        step(0, 0, 0, '0, 0, '0);
        check("t3_we", s_we, 1);
        check("t3_pc", s_pc, 26'h80);
        idle(3);
        check("t3_rc", s_rc, 2);
        check("t3_pcn", s_pcn, 0);

        // Scenario 4: buffered res not displaced by later pred.
        step(0, 1, 1, 26'h80, 0, '0);
        step(0, 1, 0, '0, 1, 26'h44);
        step(0, 0, 0, '0, 0, '0);
        check("t4_pc", s_pc, 26'h80);
        idle(3);
        check("t4_pcn", s_pcn, 0);

        // Scenario 5: simultaneous res+pred, then pred in squashed slot.
        step(0, 0, 1, 26'h20, 1, 26'h30);
        check("t5_pc", s_pc, 26'h20);
        step(0, 0, 0, '0, 1, 26'h30);
        check("t5_squashed_we", s_we, 0);
        idle(3);
        check("t5_pcn", s_pcn, 0);

        // Scenario 6: reset while a res is buffered in a stall.
        step(0, 1, 1, 26'h80, 0, '0);
        step(1, 1, 0, '0, 0, '0);
        step(0, 1, 0, '0, 0, '0);
        check("t6_pend", s_pend, 0);
        step(0, 0, 0, '0, 0, '0);
        check("t6_we", s_we, 0);

        // Saturation: more res redirects than the counter can hold.
        for (int i = 0; i < CMAX + 4; i++) step(0, 0, 1, AW'(i * 4), 0, '0);
        idle(1);
        check("sat_rc", s_rc, CMAX);
        step(0, 0, 1, 26'h200, 0, '0);
        idle(1);
        check("sat_rc_hold", s_rc, CMAX);

        // Random traffic.
        step(1, 0, 0, '0, 0, '0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 2), AW'($urandom),
                 ($urandom_range(0, 9) < 4), AW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
